// File: rtl/ef_pkg.sv
// ef_pkg: shared types, defaults and Gray helper for ef_updown_counter
package ef_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  localparam int EF_DEFAULT_WIDTH = 2;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/ef_updown_counter_if.sv
// ef_updown_counter_if: counter control/status bundle; EF_UPDOWN_GRAY_OUT_EN adds present_gray
interface ef_updown_counter_if import ef_pkg::*; #(parameter int WIDTH = EF_DEFAULT_WIDTH);
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] present;
  logic [WIDTH-1:0] next;
  logic tc;
  logic wrap;
`ifdef EF_UPDOWN_GRAY_OUT_EN
  logic [WIDTH-1:0] present_gray;
  modport master (output en, up, load, load_val, input present, next, tc, wrap, present_gray);
  modport slave (input en, up, load, load_val, output present, next, tc, wrap, present_gray);
`else
  modport master (output en, up, load, load_val, input present, next, tc, wrap);
  modport slave (input en, up, load, load_val, output present, next, tc, wrap);
`endif
endinterface

// File: rtl/ef_next_logic.sv
// ef_next_logic: combinational next-count and terminal-count for the up/down counter
module ef_next_logic import ef_pkg::*; #(
  parameter int WIDTH = EF_DEFAULT_WIDTH,
  parameter int MOD = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] present,
  input  logic en,
  input  logic up,
  input  logic load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next,
  output logic tc
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH:0] MODX = (WIDTH + 1)'(MOD);
  localparam bit SAT = SATURATE != 0;
  logic at_top, at_bot, is_up, ld_ok;
  logic [WIDTH-1:0] step;
  always_comb begin
    is_up = dir_e'(up) == DIR_UP;
    at_top = present == TOP;
    at_bot = present == '0;
    ld_ok = {1'b0, load_val} < MODX;
    step = is_up ? (at_top ? (SAT ? TOP : '0) : present + ONE)
                 : (at_bot ? (SAT ? '0 : TOP) : present - ONE);
    next = load ? (ld_ok ? load_val : '0) : en ? step : present;
    tc = en & ~load & (is_up ? at_top : at_bot);
  end
endmodule

// File: rtl/ef_updown_counter.sv
// ef_updown_counter: modulo up/down counter; EF_UPDOWN_GRAY_OUT_EN adds registered Gray output
module ef_updown_counter import ef_pkg::*; #(
  parameter int WIDTH = EF_DEFAULT_WIDTH,
  parameter int MOD = 4,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic reset,
  ef_updown_counter_if.slave bus
);
  if (WIDTH < 1 || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_params
    $error("ef_updown_counter: need WIDTH>=1 and 2 <= MOD <= 2**WIDTH");
  end
  ef_next_logic #(.WIDTH(WIDTH), .MOD(MOD), .SATURATE(SATURATE)) u_next (
    .present(bus.present),
    .en(bus.en),
    .up(bus.up),
    .load(bus.load),
    .load_val(bus.load_val),
    .next(bus.next),
    .tc(bus.tc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.present <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.present <= bus.next;
      bus.wrap <= bus.tc & (SATURATE == 0);
    end
`ifdef EF_UPDOWN_GRAY_OUT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.present_gray <= '0;
    else bus.present_gray <= WIDTH'(bin2gray(32'(bus.next)));
`endif
endmodule

// File: tb/tb_ef_updown_counter.sv
// tb_ef_updown_counter: directed checks of wrap/saturate counting, load, hold, reset and Gray output
module tb_ef_updown_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ef_updown_counter_if #(.WIDTH(2)) ia();
  ef_updown_counter_if #(.WIDTH(3)) ib();
  ef_updown_counter_if #(.WIDTH(3)) ic();
  ef_updown_counter #(.WIDTH(2), .MOD(4), .SATURATE(0)) ua (.clk(clk), .reset(reset), .bus(ia));
  ef_updown_counter #(.WIDTH(3), .MOD(5), .SATURATE(1)) ub (.clk(clk), .reset(reset), .bus(ib));
  ef_updown_counter #(.WIDTH(3), .MOD(8), .SATURATE(0)) uc (.clk(clk), .reset(reset), .bus(ic));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  int up_p[6] = '{1, 2, 3, 0, 1, 2};
  int up_w[6] = '{0, 0, 0, 1, 0, 0};
  int dn_p[5] = '{3, 2, 1, 0, 3};
  int dn_t[5] = '{1, 0, 0, 0, 1};
  int bu_p[8] = '{1, 2, 3, 4, 4, 4, 4, 4};
  int bu_t[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int bd_p[5] = '{3, 2, 1, 0, 0};
  int bd_t[5] = '{0, 0, 0, 0, 1};
  initial begin
    {ia.en, ia.up, ia.load, ia.load_val} = '0;
    {ib.en, ib.up, ib.load, ib.load_val} = '0;
    {ic.en, ic.up, ic.load, ic.load_val} = '0;
    repeat (2) tick();
    chk("reset_present", 32'(ia.present), 0);
    chk("reset_wrap", 32'(ia.wrap), 0);
    chk("reset_present_b", 32'(ib.present), 0);
`ifdef EF_UPDOWN_GRAY_OUT_EN
    chk("reset_gray", 32'(ic.present_gray), 0);
`endif
    reset = 1'b0;
    ia.en = 1'b1;
    ia.up = 1'b1;
    tick();
    chk("first_count", 32'(ia.present), 1);
    tick();
    chk("second_count", 32'(ia.present), 2);
    reset = 1'b1;
    #2;
    chk("async_reset_present", 32'(ia.present), 0);
    chk("async_reset_wrap", 32'(ia.wrap), 0);
    #1 reset = 1'b0;
    tick();
    chk("count_after_release", 32'(ia.present), 1);
    ia.load = 1'b1;
    ia.load_val = 2'd0;
    #1 chk("load0_tc", 32'(ia.tc), 0);
    tick();
    chk("load0_present", 32'(ia.present), 0);
    ia.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("up_next", 32'(ia.next), 32'(up_p[i]));
      chk("up_tc", 32'(ia.tc), 32'(up_w[i]));
      tick();
      chk("up_present", 32'(ia.present), 32'(up_p[i]));
      chk("up_wrap", 32'(ia.wrap), 32'(up_w[i]));
    end
    ia.load = 1'b1;
    ia.load_val = 2'd0;
    tick();
    ia.load = 1'b0;
    ia.up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dn_tc", 32'(ia.tc), 32'(dn_t[i]));
      tick();
      chk("dn_present", 32'(ia.present), 32'(dn_p[i]));
      chk("dn_wrap", 32'(ia.wrap), 32'(dn_t[i]));
    end
    ia.up = 1'b1;
    ia.load = 1'b1;
    ia.load_val = 2'd2;
    #1;
    chk("load_en_tc", 32'(ia.tc), 0);
    chk("load_en_next", 32'(ia.next), 2);
    tick();
    chk("load_en_present", 32'(ia.present), 2);
    ia.load = 1'b0;
    ia.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_present", 32'(ia.present), 2);
      chk("hold_next", 32'(ia.next), 2);
      chk("hold_tc", 32'(ia.tc), 0);
      chk("hold_wrap", 32'(ia.wrap), 0);
    end
    ib.en = 1'b1;
    ib.up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sat_up_tc", 32'(ib.tc), 32'(bu_t[i]));
      tick();
      chk("sat_up_present", 32'(ib.present), 32'(bu_p[i]));
      chk("sat_up_wrap", 32'(ib.wrap), 0);
    end
    ib.up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sat_dn_tc", 32'(ib.tc), 32'(bd_t[i]));
      tick();
      chk("sat_dn_present", 32'(ib.present), 32'(bd_p[i]));
      chk("sat_dn_wrap", 32'(ib.wrap), 0);
    end
    ib.load = 1'b1;
    ib.load_val = 3'd4;
    tick();
    chk("load_max_present", 32'(ib.present), 4);
    ib.load_val = 3'd6;
    #1 chk("load_oob_next", 32'(ib.next), 0);
    tick();
    chk("load_oob_present", 32'(ib.present), 0);
    ib.load = 1'b0;
    ib.en = 1'b0;
    ic.load = 1'b1;
    ic.load_val = 3'd3;
    tick();
    chk("gray_load_present", 32'(ic.present), 3);
`ifdef EF_UPDOWN_GRAY_OUT_EN
    chk("gray_at3", 32'(ic.present_gray), 32'b010);
`endif
    ic.load = 1'b0;
    ic.en = 1'b1;
    ic.up = 1'b1;
    tick();
    chk("gray_step_present", 32'(ic.present), 4);
`ifdef EF_UPDOWN_GRAY_OUT_EN
    chk("gray_at4", 32'(ic.present_gray), 32'b110);
`endif
    ic.load = 1'b1;
    ic.load_val = 3'd7;
    tick();
    ic.load = 1'b0;
    #1 chk("full_mod_tc", 32'(ic.tc), 1);
    tick();
    chk("full_mod_wrap_present", 32'(ic.present), 0);
    chk("full_mod_wrap", 32'(ic.wrap), 1);
    tick();
    chk("full_mod_wrap_clear", 32'(ic.wrap), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
